// File: rtl/atan_poly_arbiter.sv
// Shares one fixed-latency AtanPoly pipeline between NUM_REQ requesters, with a tag FIFO routing results back.
// Optional build macro ATAN_POLY_ARBITER_FIXED_PRIO_EN: fixed priority (requester 0 highest) instead of round-robin.
module atan_poly_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IN_W      = 8,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_val,
   input  logic [NUM_REQ*IN_W-1:0]      req_data,
   output logic [NUM_REQ-1:0]           req_rdy,
   output logic                         dp_val_o,
   output logic [IN_W-1:0]              dp_data_o,
   input  logic                         dp_val_i,
   input  logic [OUT_W-1:0]             dp_data_i,
   output logic [NUM_REQ-1:0]           rsp_val,
   output logic [OUT_W-1:0]             rsp_data,
   output logic [$clog2(TAG_DEPTH):0]   outstanding,
   output logic                         err_o
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned AW    = $clog2(TAG_DEPTH);
   localparam int unsigned CW    = AW + 1;

   logic [PTR_W-1:0] w_ptr;
   logic [PTR_W-1:0] w_idx;
   logic [PTR_W-1:0] w_sel;
   logic             w_hit;
   logic             w_full;
   logic             w_accept;
   logic             w_pop;
   logic [IN_W-1:0]  w_sample;

   logic             r_dp_val;
   logic [IN_W-1:0]  r_dp_data;
   logic [NUM_REQ-1:0] r_rsp_val;
   logic [OUT_W-1:0] r_rsp_data;
   logic [CW-1:0]    r_count;
   logic             r_err;
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [PTR_W-1:0] r_tags [TAG_DEPTH];

`ifdef ATAN_POLY_ARBITER_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [PTR_W-1:0] r_ptr;

   // Round-robin pointer: start the next search just past the last winner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= PTR_W'((32'(w_sel) + 1) % NUM_REQ);
      end
   end

   assign w_ptr = r_ptr;
`endif

   // First valid requester at or after the pointer, modulo NUM_REQ
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      w_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_idx = PTR_W'((32'(w_ptr) + i) % NUM_REQ);
         if (!w_hit && req_val[w_idx]) begin
            w_hit = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   always_comb begin
      w_sample = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (PTR_W'(k) == w_sel) w_sample = req_data[k*IN_W +: IN_W];
      end
   end

   // Full uses the registered count only, so a full FIFO stalls a cycle even during a pop
   assign w_full   = (r_count == CW'(TAG_DEPTH));
   assign w_accept = w_hit && !w_full;
   assign w_pop    = dp_val_i && (r_count != '0);
   assign req_rdy  = w_accept ? (NUM_REQ'(1) << w_sel) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dp_val   <= 1'b0;
         r_dp_data  <= '0;
         r_rsp_val  <= '0;
         r_rsp_data <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_tags     <= '{default: '0};
      end else begin
         r_dp_val <= w_accept;
         if (w_accept) begin
            r_dp_data    <= w_sample;
            r_tags[r_wr] <= w_sel;
            r_wr         <= r_wr + AW'(1);
         end
         r_rsp_val <= '0;
         if (w_pop) begin
            r_rsp_val  <= NUM_REQ'(1) << r_tags[r_rd];
            r_rsp_data <= dp_data_i;
            r_rd       <= r_rd + AW'(1);
         end
         if (dp_val_i && (r_count == '0)) r_err <= 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dp_val_o    = r_dp_val;
   assign dp_data_o   = r_dp_data;
   assign rsp_val     = r_rsp_val;
   assign rsp_data    = r_rsp_data;
   assign outstanding = r_count;
   assign err_o       = r_err;

endmodule

// File: tb/tb_atan_poly_arbiter.sv
// Directed bench for atan_poly_arbiter with a 3-stage stand-in for the AtanPoly pipeline.
module tb_atan_poly_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_val;
   logic [31:0] req_data;
   logic [3:0]  req_rdy;
   logic        dp_val_o;
   logic [7:0]  dp_data_o;
   logic        dp_val_i;
   logic [15:0] dp_data_i;
   logic [3:0]  rsp_val;
   logic [15:0] rsp_data;
   logic [3:0]  outstanding;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   logic        manual;
   logic        man_val;
   logic [15:0] man_data;
   logic [2:0]  p_val;
   logic [7:0]  p_d [3];

   int          gq[$];
   int          rq[$];
   logic [15:0] rdq[$];

   atan_poly_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy),
      .dp_val_o(dp_val_o), .dp_data_o(dp_data_o), .dp_val_i(dp_val_i), .dp_data_i(dp_data_i),
      .rsp_val(rsp_val), .rsp_data(rsp_data), .outstanding(outstanding), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] f(input logic [7:0] x);
      return {x ^ 8'hA5, ~x};
   endfunction

   function automatic int exp_grant(input int i);
`ifdef ATAN_POLY_ARBITER_FIXED_PRIO_EN
      return 0;
`else
      return i % 4;
`endif
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      if (!$onehot(v)) return -1;
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Stand-in datapath: fixed latency 3, no stall
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_val <= '0;
      end else begin
         p_val  <= {p_val[1:0], dp_val_o};
         p_d[0] <= dp_data_o;
         p_d[1] <= p_d[0];
         p_d[2] <= p_d[1];
      end
   end

   assign dp_val_i  = manual ? man_val  : p_val[2];
   assign dp_data_i = manual ? man_data : f(p_d[2]);

   always @(negedge clk) begin
      if (rst_n) begin
         if ((req_val & req_rdy) != 4'b0) gq.push_back(onehot_idx(req_val & req_rdy));
         if (rsp_val != 4'b0) begin
            rq.push_back(onehot_idx(rsp_val));
            rdq.push_back(rsp_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_val = '0; req_data = '0;
      manual = 1'b1; man_val = 1'b0; man_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      gq.delete(); rq.delete(); rdq.delete();
   endtask

   task automatic wait_rsp(input int n, input string name);
      for (int c = 0; c < 60 && rq.size() < n; c++) @(posedge clk);
      #1;
      checks++;
      if (rq.size() != n) begin
         errors++;
         $display("FAIL %s rsp count: got %0d expected %0d", name, rq.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_val = '0; req_data = '0;
      manual = 1'b1; man_val = 1'b0; man_data = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_rdy, dp_val_o, dp_data_o, rsp_val, rsp_data, outstanding, err_o} !== '0) begin
         errors++;
         $display("FAIL reset outputs: rdy=%b dpv=%b dpd=%h rspv=%b rspd=%h out=%0d err=%b",
                  req_rdy, dp_val_o, dp_data_o, rsp_val, rsp_data, outstanding, err_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      manual = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_val = 4'b0100;
         req_data = '0;
         req_data[23:16] = 8'(16 + i);
         #1;
         checks++;
         if (req_rdy !== 4'b0100) begin
            errors++; $display("FAIL single rdy[%0d]: got %b expected 0100", i, req_rdy);
         end
         tick();
         checks++;
         if (dp_val_o !== 1'b1 || dp_data_o !== 8'(16 + i)) begin
            errors++; $display("FAIL single issue[%0d]: val=%b data=%h expected 1/%h", i, dp_val_o, dp_data_o, 8'(16 + i));
         end
      end
      req_val = '0;
      tick();
      checks++;
      if (dp_val_o !== 1'b0 || dp_data_o !== 8'h12) begin
         errors++; $display("FAIL single idle: val=%b data=%h expected 0/12", dp_val_o, dp_data_o);
      end
      wait_rsp(3, "single");
      for (int j = 0; j < rq.size() && j < 3; j++) begin
         checks++;
         if (rq[j] != 2 || rdq[j] !== f(8'(16 + j))) begin
            errors++; $display("FAIL single rsp[%0d]: idx=%0d data=%h expected 2/%h", j, rq[j], rdq[j], f(8'(16 + j)));
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      manual = 1'b0;
      req_val = 4'hF;
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 4; k++) req_data[k*8 +: 8] = 8'(16 * c + k);
         tick();
      end
      req_val = '0;
      wait_rsp(8, "rr");
      checks++;
      if (gq.size() != 8) begin
         errors++; $display("FAIL rr grant count: got %0d expected 8", gq.size());
      end
      for (int i = 0; i < gq.size() && i < 8; i++) begin
         checks++;
         if (gq[i] != exp_grant(i)) begin
            errors++; $display("FAIL rr grant[%0d]: got %0d expected %0d", i, gq[i], exp_grant(i));
         end
      end
      for (int i = 0; i < rq.size() && i < 8; i++) begin
         checks++;
         if (rq[i] != exp_grant(i) || rdq[i] !== f(8'(16 * i + exp_grant(i)))) begin
            errors++; $display("FAIL rr rsp[%0d]: idx=%0d data=%h expected %0d/%h",
                               i, rq[i], rdq[i], exp_grant(i), f(8'(16 * i + exp_grant(i))));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_val = 4'hF;
      req_data = 32'h43424140;
      repeat (12) tick();
      checks++;
      if (req_rdy !== 4'b0 || outstanding !== 4'd8 || gq.size() != 8) begin
         errors++; $display("FAIL bp full: rdy=%b out=%0d accepts=%0d expected 0/8/8", req_rdy, outstanding, gq.size());
      end
      for (int j = 0; j < 8; j++) begin
         man_val = 1'b1;
         man_data = 16'h1000 + 16'(j);
         if (j == 0) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0) begin
               errors++; $display("FAIL bp full stall during pop: rdy=%b expected 0000", req_rdy);
            end
         end
         tick();
         req_val = '0;
      end
      man_val = 1'b0;
      tick();
      checks++;
      if (outstanding !== 4'd0 || err_o !== 1'b0 || rq.size() != 8) begin
         errors++; $display("FAIL bp drain: out=%0d err=%b rsps=%0d expected 0/0/8", outstanding, err_o, rq.size());
      end
      for (int j = 0; j < rq.size() && j < 8; j++) begin
         checks++;
         if (rq[j] != exp_grant(j) || rdq[j] !== 16'h1000 + 16'(j)) begin
            errors++; $display("FAIL bp rsp[%0d]: idx=%0d data=%h expected %0d/%h", j, rq[j], rdq[j], exp_grant(j), 16'h1000 + 16'(j));
         end
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      req_val = 4'b0001; tick();
      req_val = 4'b0010; tick();
      req_val = 4'b0100; tick();
      checks++;
      if (outstanding !== 4'd3) begin
         errors++; $display("FAIL pp setup: out=%0d expected 3", outstanding);
      end
      req_val = 4'b1000; man_val = 1'b1; man_data = 16'hBEEF;
      #1;
      checks++;
      if (req_rdy !== 4'b1000) begin
         errors++; $display("FAIL pp rdy: got %b expected 1000", req_rdy);
      end
      tick();
      req_val = '0; man_val = 1'b0;
      checks++;
      if (outstanding !== 4'd3 || rsp_val !== 4'b0001 || rsp_data !== 16'hBEEF) begin
         errors++; $display("FAIL pp same-cycle: out=%0d rspv=%b rspd=%h expected 3/0001/beef", outstanding, rsp_val, rsp_data);
      end
      tick();
      checks++;
      if (rsp_val !== 4'b0 || rsp_data !== 16'hBEEF || outstanding !== 4'd3) begin
         errors++; $display("FAIL pp pulse: rspv=%b rspd=%h out=%0d expected 0000/beef/3", rsp_val, rsp_data, outstanding);
      end
   endtask

   task automatic test_error();
      do_reset();
      man_val = 1'b1; man_data = 16'h1234;
      tick();
      man_val = 1'b0;
      checks++;
      if (rsp_val !== 4'b0 || err_o !== 1'b1 || outstanding !== 4'd0 || rsp_data !== 16'h0) begin
         errors++; $display("FAIL err empty pop: rspv=%b err=%b out=%0d rspd=%h expected 0000/1/0/0000", rsp_val, err_o, outstanding, rsp_data);
      end
      manual = 1'b0;
      req_val = 4'b0011;
      repeat (4) tick();
      req_val = '0;
      repeat (8) tick();
      checks++;
      if (err_o !== 1'b1 || outstanding !== 4'd0) begin
         errors++; $display("FAIL err sticky: err=%b out=%0d expected 1/0", err_o, outstanding);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err clear on reset: got %b expected 0", err_o);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset();
      manual = 1'b0;
      req_val = 4'hF;
      req_data = 32'h77665544;
      repeat (3) tick();
      checks++;
      if (dp_val_o !== 1'b1) begin
         errors++; $display("FAIL async pre-reset dp_val_o: got %b expected 1", dp_val_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dp_val_o, dp_data_o, rsp_val, rsp_data, outstanding, err_o} !== '0) begin
         errors++; $display("FAIL async reset: dpv=%b dpd=%h rspv=%b rspd=%h out=%0d err=%b",
                            dp_val_o, dp_data_o, rsp_val, rsp_data, outstanding, err_o);
      end
      req_val = '0;
      tick();
      rst_n = 1'b1;
      req_val = 4'hF;
      #1;
      checks++;
      if (req_rdy !== 4'b0001) begin
         errors++; $display("FAIL async restart grant: got %b expected 0001", req_rdy);
      end
      req_val = '0;
      repeat (8) tick();
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL async no stray error: got %b expected 0", err_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_push_pop();
      test_error();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/atan_poly_arbiter.md
Name: atan_poly_arbiter

Overview:
- Shares one AtanPoly evaluation pipeline (8-bit in, 16-bit out, fixed latency, no stall) between NUM_REQ requesters.
- Round-robin grant selects at most one sample per cycle and drives the datapath.
- A tag FIFO records each issued sample's requester index. On each datapath result, the oldest tag is popped and the result is routed back to that requester.
- Sits between the front-end sample sources and the AtanPoly instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IN_W, 8, datapath input width
OUT_W, 16, datapath output width
TAG_DEPTH, 8, max outstanding samples in flight (power of 2, must be ≥ pipeline latency + 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_val  in  NUM_REQ  per-requester sample valid
req_data  in  NUM_REQ*IN_W  packed samples; requester k at bits [k*IN_W +: IN_W]
req_rdy  out  NUM_REQ  one-hot grant; sample accepted when req_val[k] & req_rdy[k]
dp_val_o  out  1  to AtanPoly val_i
dp_data_o  out  IN_W  to AtanPoly atan_poly_i
dp_val_i  in  1  from AtanPoly val_o
dp_data_i  in  OUT_W  from AtanPoly atan_poly_o
rsp_val  out  NUM_REQ  one-hot result valid pulse, one cycle
rsp_data  out  OUT_W  result data, valid with rsp_val
outstanding  out  $clog2(TAG_DEPTH)+1  tags currently in FIFO
err_o  out  1  sticky: result arrived with empty tag FIFO

Behaviour:
- Reset (async assert, sync release): all outputs and internal state are 0. This covers dp_val_o, dp_data_o, rsp_val, rsp_data, err_o, outstanding, round-robin pointer ptr, and FIFO read/write pointers.
- Grant (combinational):
  - If outstanding == TAG_DEPTH, req_rdy = 0.
  - Otherwise req_rdy has one bit set: the first k with req_val[k] = 1, searching ptr, ptr+1, … modulo NUM_REQ.
  - If no req_val is set, req_rdy = 0.
  - req_rdy never asserts for a requester with req_val = 0.
- Issue (registered):
  - On accept of requester k: dp_val_o <= 1, dp_data_o <= sample k, push tag k, ptr <= (k+1) mod NUM_REQ.
  - With no accept: dp_val_o <= 0, dp_data_o holds its value, ptr holds.
- Throughput: one sample per cycle, no bubbles, while the FIFO is not full.
- Return path:
  - On dp_val_i = 1 with FIFO not empty: pop tag t; next cycle rsp_val <= (1 << t), rsp_data <= dp_data_i.
  - Otherwise rsp_val <= 0 and rsp_data holds.
  - Added latency is 1 cycle from dp_val_i.
- End-to-end latency: accept → dp_val_o is 1 cycle; + AtanPoly latency; + 1 cycle to rsp_val.
- Results return in issue order; tags are strictly FIFO.
- Push and pop in the same cycle: both take effect and outstanding is unchanged. Full-status evaluation uses the registered count only (no same-cycle bypass), so a full FIFO stalls one cycle even if a pop occurs.
- Pop when empty (dp_val_i = 1, outstanding = 0):
  - No pop, pointers unchanged, rsp_val stays 0.
  - err_o <= 1 and remains set until reset.
- Pointer wrap: FIFO pointers wrap modulo TAG_DEPTH; the count is saturation-free by construction.
- Reset mid-operation: in-flight tags are discarded. Results still emerging from AtanPoly after reset hit an empty FIFO and set err_o; system integration resets both blocks together.

Optional Feature:
ATAN_POLY_ARBITER_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins (requester 0 highest). ptr is not implemented and is constant 0.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester: req_val = 4'b0100, data 0x10,0x11,0x12 in 3 consecutive cycles → req_rdy = 4'b0100 each cycle; dp_val_o high 3 cycles with 0x10..0x12; rsp_val = 4'b0100 three times, with rsp_data matching the reference model outputs in order.
- Round-robin fairness: all 4 requesters hold req_val = 1 for 8 cycles → grant order 0,1,2,3,0,1,2,3; each rsp_val bit pulses twice, in the same order.
- Backpressure: tie dp_val_i = 0 and all req_val = 1 for 12 cycles → exactly 8 accepts; outstanding = 8; req_rdy = 0 thereafter. Then release 8 dp_val_i pulses → outstanding returns to 0 and rsp order matches grant order.
- Simultaneous push/pop: outstanding = 3, accept and dp_val_i in the same cycle → outstanding stays 3; rsp_val one-hot to the oldest tag.
- Error: after reset, pulse dp_val_i = 1 with data 0x1234 → rsp_val stays 0, err_o = 1 next cycle and remains 1 through further traffic until rst_n = 0.
- Async reset mid-burst: assert rst_n = 0 between clock edges → outputs 0 immediately. Rerun with ATAN_POLY_ARBITER_FIXED_PRIO_EN defined and all requesters active → requester 0 wins every cycle.
